prv32_muldiv: RTL and testbench

//  Iterative RV32M multiply/divide unit beside prv32_ALU in the EX stage of the pipelined core.
//  The pipeline launches an M-extension op with a start pulse and stalls on busy.
//  The result is returned with a one-cycle done pulse.

---
 rtl/prv32_muldiv.sv | 134 +++++++++++++
 tb/tb_prv32_muldiv.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/prv32_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// one operand bit per cycle, launched by start and finished with a one-cycle done pulse.
module prv32_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] r
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [4:0] LAST = 5'(XLEN - 1);

  state_t            state;
  logic [4:0]        cnt;
  logic [2:0]        op;
  logic              sign_a, sign_b, special;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] acc;

  logic            sa_in, sb_in, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a_in, mag_b_in, spec_val;

  always_comb begin
    sa_in    = a[XLEN-1] & (funct3 == 3'b001 || funct3 == 3'b010 ||
                            funct3 == 3'b100 || funct3 == 3'b110);
    sb_in    = b[XLEN-1] & (funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b110);
    mag_a_in = sa_in ? -a : a;
    mag_b_in = sb_in ? -b : b;
    div_zero = funct3[2] && (b == '0);
    div_ovf  = funct3[2] && !funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    // REM by zero returns the dividend; signed-overflow REM returns 0
    if (funct3[1]) spec_val = div_zero ? a : '0;
    else           spec_val = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
  end

  logic [XLEN:0]     mul_sum, div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] mul_next, div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    // shifted partial remainder needs one extra bit before the compare
    div_sh   = acc[2*XLEN-1:XLEN-1];
    div_ge   = div_sh >= {1'b0, mag_b};
    div_rem  = div_ge ? XLEN'(div_sh - {1'b0, mag_b}) : div_sh[XLEN-1:0];
    div_next = {div_rem, acc[XLEN-2:0], div_ge};
  end

  logic              neg;
  logic [2*XLEN-1:0] mul_res;
  logic [XLEN-1:0]   fix_r;

  always_comb begin
    neg     = (op[2] && op[1]) ? sign_a : (sign_a ^ sign_b);
    mul_res = neg ? -acc : acc;
    case (op)
      3'b000:                 fix_r = mul_res[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_r = mul_res[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_r = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      default:                fix_r = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      special <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      r       <= '0;
    end else if (flush && state != IDLE) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !flush) begin
          op     <= funct3;
          sign_a <= sa_in;
          sign_b <= sb_in;
          mag_a  <= mag_a_in;
          mag_b  <= mag_b_in;
          cnt    <= '0;
          busy   <= 1'b1;
          done   <= 1'b0;
          if (div_zero || div_ovf) begin
            special <= 1'b1;
            acc     <= {{XLEN{1'b0}}, spec_val};
            state   <= FIX;
          end else begin
            special <= 1'b0;
            // low half holds the dividend for divide, the multiplier for multiply
            acc     <= {{XLEN{1'b0}}, funct3[2] ? mag_a_in : mag_b_in};
            state   <= CALC;
          end
        end
        CALC: begin
          acc <= op[2] ? div_next : mul_next;
          cnt <= cnt + 5'd1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          r     <= special ? acc[XLEN-1:0] : fix_r;
          done  <= 1'b1;
          state <= DONE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prv32_muldiv.sv
// Bench for prv32_muldiv: arithmetic reference model with a cycle countdown,
// checked every cycle, plus directed literal cases and randomized operations.
module tb_prv32_muldiv;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  funct3;
  logic [31:0] a, b, r;
  logic        busy, done;

  int n_pass = 0;
  int n_total = 0;

  prv32_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .a(a), .b(b), .flush(flush), .busy(busy), .done(done), .r(r)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_r(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, ux, uy;
    logic [63:0] p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (f)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
        return 32'($signed(x) / $signed(y));
      end
      3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
        return 32'($signed(x) % $signed(y));
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    return f[2] && (y == 0 || (!f[0] && x == 32'h80000000 && y == 32'hFFFFFFFF));
  endfunction

  // model: cycles left until done for the op in flight
  logic        m_busy = 0, m_done = 0;
  logic [31:0] m_r = 0, m_pend = 0;
  int          m_left = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_r = 0; m_left = 0;
    end else if (m_busy) begin
      if (flush) begin
        m_busy = 0; m_done = 0; m_left = 0;
      end else if (m_done) begin
        m_busy = 0; m_done = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin m_done = 1; m_r = m_pend; end
      end
    end else if (start && !flush) begin
      m_pend = ref_r(funct3, a, b);
      m_left = is_special(funct3, a, b) ? 1 : 33;
      m_busy = 1;
    end
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("r", r, m_r);
  end

  task automatic launch(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk); #1;
    start = 1; funct3 = f; a = x; b = y;
    @(negedge clk); #1;
    start = 0;
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int lat, input string name);
    int n;
    launch(f, x, y);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_lat"}, 32'(n), 32'(lat));
    check({name, "_r"}, r, exp);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] old_r, x, y;
    logic [2:0]  f;
    bit          saw;
    rst_n = 0; start = 0; flush = 0; funct3 = 0; a = 0; b = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_r", r, 32'd0);
    #1 rst_n = 1;

    check("ref_mul", ref_r(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    check("ref_mulh", ref_r(3'd1, 32'h80000000, 32'h80000000), 32'h40000000);
    check("ref_mulhu", ref_r(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
    check("ref_mulhsu", ref_r(3'd2, 32'hFFFFFFFF, 32'd2), 32'hFFFFFFFF);
    check("ref_div", ref_r(3'd4, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
    check("ref_rem", ref_r(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);

    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul");
    run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh");
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu");
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33, "mulhsu");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 33, "divu");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 33, "remu");
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "div");
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, "rem");
    run_op(3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "div0");
    run_op(3'd6, 32'd5, 32'd0, 32'd5, 1, "rem0");
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "divovf");
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, "removf");
    run_op(3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h0, 33, "divu_big");

    // flush at CALC cycle 10
    run_op(3'd0, 32'd9, 32'd9, 32'd81, 33, "pre_flush");
    old_r = r;
    launch(3'd0, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    #1 flush = 1;
    @(negedge clk);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_r", r, old_r);
    #1 flush = 0;
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw = 1;
    end
    check("flush_nodone", 32'(saw), 32'd0);

    // flush and start together in IDLE
    @(negedge clk); #1;
    start = 1; flush = 1; funct3 = 3'd0; a = 32'd2; b = 32'd2;
    @(negedge clk);
    check("flush_start_busy", 32'(busy), 32'd0);
    #1 start = 0; flush = 0;

    // reset mid-CALC
    launch(3'd3, 32'h12345678, 32'h9ABCDEF0);
    repeat (5) @(negedge clk);
    #1 rst_n = 0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_r", r, 32'd0);
    @(negedge clk); #1 rst_n = 1;

    // second start while busy is ignored
    launch(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (3) @(negedge clk);
    #1 start = 1; funct3 = 3'd4; a = 32'd5; b = 32'd0;
    @(negedge clk); #1 start = 0;
    begin
      int n = 4;
      while (!done && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("busy_start_lat", 32'(n), 32'd33);
      check("busy_start_r", r, 32'hFFFFFFFE);
    end

    // randomized operations; the per-cycle compare checks against the model
    for (int i = 0; i < 250; i++) begin
      f = 3'($urandom_range(0, 7));
      x = rnd_val();
      y = rnd_val();
      if ($urandom_range(0, 7) == 0) begin
        launch(f, x, y);
        repeat ($urandom_range(0, 34)) @(negedge clk);
        #1 flush = 1;
        @(negedge clk); #1 flush = 0;
        @(negedge clk);
      end else begin
        run_op(f, x, y, ref_r(f, x, y), is_special(f, x, y) ? 1 : 33, "rnd");
        // sometimes hold start through the done cycle; it must be ignored there
        if ($urandom_range(0, 3) == 0) begin
          #1 start = 1; funct3 = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
        end
      end
    end
    @(negedge clk); #1 start = 0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
